// File: rtl/output_line_packer_pkg.sv
// output_line_packer_pkg: shared widths, lane derivation, FSM states and the packed output word layout.
package output_line_packer_pkg;

   localparam int ACTIVATION_BIT_WIDTH           = 8;
   localparam int ACTIVATION_BANK_BIT_WIDTH      = 64;
   localparam int OUTPUT_WRITER_ADDRESS_BIT_WIDTH = 14;
   localparam int WORD_COUNT_BIT_WIDTH           = 16;

   function automatic int lanes(input int act_w, input int bank_w);
      return bank_w / act_w;
   endfunction

   localparam int LANES = lanes(ACTIVATION_BIT_WIDTH, ACTIVATION_BANK_BIT_WIDTH);

   typedef enum logic {IDLE, PACK} state_t;

   typedef struct packed {
      logic [ACTIVATION_BANK_BIT_WIDTH-1:0]      array;
      logic [OUTPUT_WRITER_ADDRESS_BIT_WIDTH-1:0] address;
      logic                                      last;
   } output_word_t;

endpackage

// File: rtl/output_line_packer_word_register.sv
// output_word_register: single-entry valid/ready holding register; can drain and refill in the same cycle.
module output_word_register #(
   parameter type word_t = output_line_packer_pkg::output_word_t
) (
   input  logic  clk,
   input  logic  reset,
   input  word_t in_word,
   input  logic  in_valid,
   output logic  in_ready,
   output word_t out_word,
   output logic  out_valid,
   input  logic  out_ready
);

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_word  <= '0;
         out_valid <= 1'b0;
      end else if (in_valid && in_ready) begin
         out_word  <= in_word;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/output_line_packer.sv
// output_line_packer: packs quantized activations into bank-wide words and writes them to sequential addresses.
module output_line_packer #(
   parameter int ACTIVATION_BIT_WIDTH            = output_line_packer_pkg::ACTIVATION_BIT_WIDTH,
   parameter int ACTIVATION_BANK_BIT_WIDTH       = output_line_packer_pkg::ACTIVATION_BANK_BIT_WIDTH,
   parameter int OUTPUT_WRITER_ADDRESS_BIT_WIDTH = output_line_packer_pkg::OUTPUT_WRITER_ADDRESS_BIT_WIDTH,
   parameter int WORD_COUNT_BIT_WIDTH            = output_line_packer_pkg::WORD_COUNT_BIT_WIDTH
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       i_start,
   input  logic [OUTPUT_WRITER_ADDRESS_BIT_WIDTH-1:0] i_base_address,
   input  logic [ACTIVATION_BIT_WIDTH-1:0]            i_activation,
   input  logic                                       i_last_in_line,
   input  logic                                       i_valid,
   output logic                                       o_ready,
   output logic [ACTIVATION_BANK_BIT_WIDTH-1:0]       o_output_array,
   output logic [OUTPUT_WRITER_ADDRESS_BIT_WIDTH-1:0] o_output_address,
   output logic                                       o_output_valid,
   input  logic                                       i_output_ready,
   output logic                                       o_output_line_stored,
   output logic [WORD_COUNT_BIT_WIDTH-1:0]            o_words_written
);
   import output_line_packer_pkg::*;

   localparam int LANES_P = lanes(ACTIVATION_BIT_WIDTH, ACTIVATION_BANK_BIT_WIDTH);
   localparam int LANE_W  = $clog2(LANES_P);

   typedef struct packed {
      logic [ACTIVATION_BANK_BIT_WIDTH-1:0]       array;
      logic [OUTPUT_WRITER_ADDRESS_BIT_WIDTH-1:0] address;
      logic                                       last;
   } word_t;

   state_t                                     state;
   logic [LANE_W-1:0]                          lane_cnt;
   logic [ACTIVATION_BANK_BIT_WIDTH-1:0]       acc;
   logic [ACTIVATION_BANK_BIT_WIDTH-1:0]       merged;
   logic [OUTPUT_WRITER_ADDRESS_BIT_WIDTH-1:0] addr_cnt;
   logic                                       reg_ready;
   logic                                       accept;
   logic                                       complete;
   logic                                       drained;
   word_t                                      in_word;
   word_t                                      out_word;

   // Lanes at and above lane_cnt are always zero, so OR-ing in the new lane is enough.
   assign merged   = acc | (ACTIVATION_BANK_BIT_WIDTH'(i_activation) << (ACTIVATION_BIT_WIDTH * lane_cnt));
   assign o_ready  = (state == PACK) && !i_start && reg_ready;
   assign accept   = i_valid && o_ready;
   assign complete = accept && (i_last_in_line || lane_cnt == LANE_W'(LANES_P - 1));
   assign in_word  = '{array: merged, address: addr_cnt, last: i_last_in_line};
   assign drained  = o_output_valid && i_output_ready;

   output_word_register #(.word_t(word_t)) u_word_register (
      .clk       (clk),
      .reset     (reset),
      .in_word   (in_word),
      .in_valid  (complete),
      .in_ready  (reg_ready),
      .out_word  (out_word),
      .out_valid (o_output_valid),
      .out_ready (i_output_ready)
   );

   assign o_output_array   = out_word.array;
   assign o_output_address = out_word.address;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                <= IDLE;
         lane_cnt             <= '0;
         acc                  <= '0;
         addr_cnt             <= '0;
         o_output_line_stored <= 1'b0;
         o_words_written      <= '0;
      end else begin
         o_output_line_stored <= drained && out_word.last;
         if (i_start) begin
            state           <= PACK;
            lane_cnt        <= '0;
            acc             <= '0;
            addr_cnt        <= i_base_address;
            o_words_written <= '0;
         end else begin
            if (drained && o_words_written != '1)
               o_words_written <= o_words_written + 1'b1;
            if (complete) begin
               lane_cnt <= '0;
               acc      <= '0;
               addr_cnt <= addr_cnt + 1'b1;
            end else if (accept) begin
               lane_cnt <= lane_cnt + 1'b1;
               acc      <= merged;
            end
         end
      end
   end

endmodule
